// File: rtl/decode_stage_p.sv
// MIPS decode stage: register file with write-first bypass, immediate/dest decode,
// load-use hazard detection and a single valid/ready output register with stall refresh.
module decode_stage_p #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int LINK_REG   = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instruction,
  input  logic [DATA_W-1:0]     pc_plus4,
  input  logic                  wb_valid,
  input  logic [1:0]            wb_sel,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic [DATA_W-1:0]     wb_link,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     rs_data,
  output logic [DATA_W-1:0]     rt_data,
  output logic [DATA_W-1:0]     imm_ext,
  output logic [REG_ADDR_W-1:0] dest,
  output logic                  is_load,
  output logic [DATA_W-1:0]     out_pc_plus4
);

  localparam int NREG = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0]     regs [NREG];
  logic [DATA_W-1:0]     wb_data;
  logic                  we;
  logic [5:0]            opcode;
  logic [15:0]           imm16;
  logic [REG_ADDR_W-1:0] rs_a;
  logic [REG_ADDR_W-1:0] rt_a;
  logic [REG_ADDR_W-1:0] rd_a;
  logic [REG_ADDR_W-1:0] d_dest;
  logic [DATA_W-1:0]     d_imm;
  logic [DATA_W-1:0]     rd_rs;
  logic [DATA_W-1:0]     rd_rt;
  logic                  d_load;
  logic                  rs_used;
  logic                  rt_used;
  logic                  hazard;
  logic                  capture;
  logic [REG_ADDR_W-1:0] hold_rs;
  logic [REG_ADDR_W-1:0] hold_rt;

  always_comb begin
    case (wb_sel)
      2'b00:   wb_data = alu_result;
      2'b01:   wb_data = mem_data;
      2'b10:   wb_data = wb_link;
      default: wb_data = '0;
    endcase
  end

  // Register 0 is never written, so it keeps its reset value of zero forever.
  assign we = wb_valid && (wb_sel != 2'b11) && (wb_rd != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wb_rd] <= wb_data;
    end
  end

  assign opcode = instruction[31:26];
  assign imm16  = instruction[15:0];
  assign rs_a   = REG_ADDR_W'(instruction[25:21]);
  assign rt_a   = REG_ADDR_W'(instruction[20:16]);
  assign rd_a   = REG_ADDR_W'(instruction[15:11]);

  always_comb begin
    d_imm = '0;
    case (opcode)
      6'h0C, 6'h0D, 6'h0E: d_imm = DATA_W'(imm16);
      6'h0F:               d_imm = DATA_W'({imm16, 16'h0000});
      default: begin
        d_imm        = {DATA_W{imm16[15]}};
        d_imm[15:0]  = imm16;
      end
    endcase
  end

  always_comb begin
    d_dest = rt_a;
    case (opcode)
      6'h00:                      d_dest = rd_a;
      6'h03:                      d_dest = REG_ADDR_W'(LINK_REG);
      6'h02, 6'h04, 6'h05, 6'h2B: d_dest = '0;
      default:                    d_dest = rt_a;
    endcase
  end

  assign d_load  = (opcode == 6'h23);
  assign rs_used = !((opcode == 6'h02) || (opcode == 6'h03));
  assign rt_used = opcode inside {6'h00, 6'h04, 6'h05, 6'h2B};

  // Write-first reads; we excludes wb_rd==0 so register 0 is never bypassed.
  assign rd_rs = (we && (wb_rd == rs_a)) ? wb_data : regs[rs_a];
  assign rd_rt = (we && (wb_rd == rt_a)) ? wb_data : regs[rt_a];

  assign hazard = out_valid && is_load && (dest != '0) &&
                  ((rs_used && (rs_a == dest)) || (rt_used && (rt_a == dest)));

  // Handshake: a transfer happens on a rising edge where valid && ready; a producer
  // holding valid keeps its payload stable until accepted. in_ready is low in reset.
  assign in_ready = rst && (!out_valid || out_ready) && !hazard;
  assign capture  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      rs_data      <= '0;
      rt_data      <= '0;
      imm_ext      <= '0;
      dest         <= '0;
      is_load      <= 1'b0;
      out_pc_plus4 <= '0;
      hold_rs      <= '0;
      hold_rt      <= '0;
    end else if (capture) begin
      out_valid    <= 1'b1;
      rs_data      <= rd_rs;
      rt_data      <= rd_rt;
      imm_ext      <= d_imm;
      dest         <= d_dest;
      is_load      <= d_load;
      out_pc_plus4 <= pc_plus4;
      hold_rs      <= rs_a;
      hold_rt      <= rt_a;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      // A stalled bundle tracks writebacks to its source registers.
      if (we && (wb_rd == hold_rs)) rs_data <= wb_data;
      if (we && (wb_rd == hold_rt)) rt_data <= wb_data;
    end
  end

endmodule

// File: tb/tb_decode_stage_p.sv
// Bench for decode_stage_p: directed scenarios plus a randomized run checked
// against a spec-level model of the register file and the output bundle.
module tb_decode_stage_p;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic [31:0] pc_plus4;
  logic        wb_valid;
  logic [1:0]  wb_sel;
  logic [4:0]  wb_rd;
  logic [31:0] alu_result;
  logic [31:0] mem_data;
  logic [31:0] wb_link;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm_ext;
  logic [4:0]  dest;
  logic        is_load;
  logic [31:0] out_pc_plus4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mreg [32];
  logic [4:0]  exp_q [$];

  typedef struct {
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [4:0]  rs_f;
    logic [4:0]  rt_f;
    logic        is_load;
  } bundle_t;

  logic [5:0] ops [13] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C,
                           6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h23, 6'h2B};

  decode_stage_p #(.DATA_W(32), .REG_ADDR_W(5), .LINK_REG(31)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc_plus4(pc_plus4), .wb_valid(wb_valid),
    .wb_sel(wb_sel), .wb_rd(wb_rd), .alu_result(alu_result), .mem_data(mem_data),
    .wb_link(wb_link), .out_valid(out_valid), .out_ready(out_ready),
    .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext), .dest(dest),
    .is_load(is_load), .out_pc_plus4(out_pc_plus4)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic uses_rs(input logic [5:0] op);
    return !(op == 6'h02 || op == 6'h03);
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    return (op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2B);
  endfunction

  function automatic bundle_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                           input logic w_en, input logic [4:0] w_rd,
                                           input logic [31:0] w_data);
    bundle_t    b;
    logic [5:0] op;
    op        = ins[31:26];
    b.rs_f    = ins[25:21];
    b.rt_f    = ins[20:16];
    b.pc      = pc;
    b.is_load = (op == 6'h23);
    if (op == 6'h0C || op == 6'h0D || op == 6'h0E) b.imm = {16'h0000, ins[15:0]};
    else if (op == 6'h0F)                           b.imm = {ins[15:0], 16'h0000};
    else                                            b.imm = {{16{ins[15]}}, ins[15:0]};
    if (op == 6'h00)      b.dest = ins[15:11];
    else if (op == 6'h03) b.dest = 5'd31;
    else if (op == 6'h02 || op == 6'h04 || op == 6'h05 || op == 6'h2B) b.dest = 5'd0;
    else                  b.dest = ins[20:16];
    b.rs_data = (w_en && w_rd == b.rs_f) ? w_data : mreg[b.rs_f];
    b.rt_data = (w_en && w_rd == b.rt_f) ? w_data : mreg[b.rt_f];
    return b;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; instruction = '0; pc_plus4 = '0;
    wb_valid = 1'b0; wb_sel = 2'b11; wb_rd = '0;
    alu_result = '0; mem_data = '0; wb_link = '0; out_ready = 1'b1;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] v);
    wb_valid = 1'b1; wb_sel = 2'b00; wb_rd = rd; alu_result = v;
    step();
    wb_valid = 1'b0;
    if (rd != 5'd0) mreg[rd] = v;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    int t;
    t = 0;
    in_valid = 1'b1; instruction = ins; pc_plus4 = pc;
    #1;
    while (!in_ready && t < 10) begin
      step(); #1; t++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL issue_timeout: in_ready=%b required 1 for %h", in_ready, ins);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    step(); step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b exp 0", in_ready); end
    n_checks++; if (rs_data !== 32'h0 || imm_ext !== 32'h0 || dest !== 5'd0) begin
      n_fail++; $display("FAIL rst_fields: rs=%h imm=%h dest=%0d exp all 0", rs_data, imm_ext, dest); end
    rst = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b exp 1", in_ready); end
    step();
  endtask

  task automatic test_add();
    wr(5'd2, 32'd2);
    wr(5'd3, 32'd3);
    issue(32'h00433820, 32'h0000_0104);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b exp 1", out_valid); end
    n_checks++; if (rs_data !== 32'd2) begin n_fail++; $display("FAIL add_rs: got %h exp 2", rs_data); end
    n_checks++; if (rt_data !== 32'd3) begin n_fail++; $display("FAIL add_rt: got %h exp 3", rt_data); end
    n_checks++; if (dest !== 5'd7) begin n_fail++; $display("FAIL add_dest: got %0d exp 7", dest); end
    n_checks++; if (imm_ext !== 32'h3820 || is_load !== 1'b0 || out_pc_plus4 !== 32'h104) begin
      n_fail++; $display("FAIL add_misc: imm=%h load=%b pc=%h exp 3820 0 104", imm_ext, is_load, out_pc_plus4); end
  endtask

  task automatic test_imm();
    issue(32'h20E38037, 32'h10);
    n_checks++; if (imm_ext !== 32'hFFFF8037 || dest !== 5'd3) begin
      n_fail++; $display("FAIL addi_sext: imm=%h dest=%0d exp FFFF8037 3", imm_ext, dest); end
    issue(32'h30448097, 32'h14);
    n_checks++; if (imm_ext !== 32'h00008097 || dest !== 5'd4) begin
      n_fail++; $display("FAIL andi_zext: imm=%h dest=%0d exp 00008097 4", imm_ext, dest); end
    n_checks++; if (rs_data !== 32'd2) begin n_fail++; $display("FAIL andi_rs: got %h exp 2", rs_data); end
    issue(32'h3C051234, 32'h18);
    n_checks++; if (imm_ext !== 32'h12340000 || dest !== 5'd5) begin
      n_fail++; $display("FAIL lui: imm=%h dest=%0d exp 12340000 5", imm_ext, dest); end
  endtask

  task automatic test_hazard();
    issue(32'h8C060100, 32'h20);
    n_checks++; if (is_load !== 1'b1 || dest !== 5'd6 || imm_ext !== 32'h100) begin
      n_fail++; $display("FAIL lw_fields: load=%b dest=%0d imm=%h exp 1 6 100", is_load, dest, imm_ext); end
    in_valid = 1'b1; instruction = 32'h00C64020; pc_plus4 = 32'h24; out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hz_stall: in_ready=%b exp 0", in_ready); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hz_bubble: out_valid=%b exp 0", out_valid); end
    wb_valid = 1'b1; wb_sel = 2'b01; wb_rd = 5'd6; mem_data = 32'h7B;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hz_release: in_ready=%b exp 1", in_ready); end
    step();
    in_valid = 1'b0; wb_valid = 1'b0; mreg[6] = 32'h7B;
    n_checks++; if (out_valid !== 1'b1 || dest !== 5'd8) begin
      n_fail++; $display("FAIL hz_issue: valid=%b dest=%0d exp 1 8", out_valid, dest); end
    n_checks++; if (rs_data !== 32'h7B || rt_data !== 32'h7B) begin
      n_fail++; $display("FAIL hz_bypass: rs=%h rt=%h exp 7b 7b", rs_data, rt_data); end
  endtask

  task automatic test_wb_sources();
    issue(32'h0C000010, 32'h30);
    n_checks++; if (dest !== 5'd31) begin n_fail++; $display("FAIL jal_dest: got %0d exp 31", dest); end
    wb_valid = 1'b1; wb_sel = 2'b10; wb_rd = 5'd31; wb_link = 32'h18;
    alu_result = 32'hAAAA; mem_data = 32'hBBBB;
    step();
    wb_valid = 1'b0; mreg[31] = 32'h18;
    issue(32'h03E00820, 32'h34);
    n_checks++; if (rs_data !== 32'h18) begin n_fail++; $display("FAIL link_write: x31=%h exp 18", rs_data); end
    wb_valid = 1'b1; wb_sel = 2'b11; wb_rd = 5'd2;
    alu_result = 32'hDEAD; mem_data = 32'hDEAD; wb_link = 32'hDEAD;
    step();
    wb_valid = 1'b0;
    issue(32'h00400820, 32'h38);
    n_checks++; if (rs_data !== 32'd2) begin n_fail++; $display("FAIL sel11_nowrite: x2=%h exp 2", rs_data); end
    wr(5'd0, 32'hFFFF);
    issue(32'h00000820, 32'h3C);
    n_checks++; if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
      n_fail++; $display("FAIL x0_zero: rs=%h rt=%h exp 0 0", rs_data, rt_data); end
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    issue(32'h00433820, 32'h40);
    out_ready = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b exp 0", in_ready); end
    wr(5'd3, 32'h55);
    n_checks++; if (out_valid !== 1'b1 || rt_data !== 32'h55) begin
      n_fail++; $display("FAIL stall_refresh: valid=%b rt=%h exp 1 55", out_valid, rt_data); end
    n_checks++; if (rs_data !== 32'd2 || dest !== 5'd7 || imm_ext !== 32'h3820 || out_pc_plus4 !== 32'h40) begin
      n_fail++; $display("FAIL stall_hold: rs=%h dest=%0d imm=%h pc=%h exp 2 7 3820 40", rs_data, dest, imm_ext, out_pc_plus4); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready2: got %b exp 0", in_ready); end
  endtask

  task automatic test_reset_mid_stall();
    rst = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async: valid=%b ready=%b exp 0 0", out_valid, in_ready); end
    n_checks++; if (rt_data !== 32'h0) begin n_fail++; $display("FAIL midrst_data: rt=%h exp 0", rt_data); end
    step();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    out_ready = 1'b1;
    issue(32'h00433820, 32'h50);
    n_checks++; if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
      n_fail++; $display("FAIL midrst_regs: rs=%h rt=%h exp 0 0", rs_data, rt_data); end
    issue(32'h03E63020, 32'h54);
    n_checks++; if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
      n_fail++; $display("FAIL midrst_regs2: rs=%h rt=%h exp 0 0", rs_data, rt_data); end
    step(); step();
  endtask

  task automatic test_random();
    bundle_t     eb;
    logic        eov;
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [15:0] imm16;
    logic        hz, er, w_en;
    logic [31:0] w_data;
    logic [4:0]  qd;
    eov = 1'b0;
    eb  = model_decode(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int c = 0; c < 400; c++) begin
      op    = ops[$urandom_range(0, 12)];
      rs    = 5'($urandom_range(0, 7));
      rt    = 5'($urandom_range(0, 7));
      imm16 = 16'($urandom);
      if (op == 6'h00) imm16[15:11] = 5'($urandom_range(0, 7));
      in_valid    = 1'($urandom_range(0, 1));
      instruction = {op, rs, rt, imm16};
      pc_plus4    = $urandom;
      wb_valid    = 1'($urandom_range(0, 1));
      wb_sel      = 2'($urandom_range(0, 3));
      wb_rd       = 5'($urandom_range(0, 7));
      alu_result  = $urandom; mem_data = $urandom; wb_link = $urandom;
      out_ready   = ($urandom_range(0, 3) != 0);
      #1;
      hz = eov && eb.is_load && (eb.dest != 5'd0) &&
           ((uses_rs(op) && rs == eb.dest) || (uses_rt(op) && rt == eb.dest));
      er = (!eov || out_ready) && !hz;
      n_checks++;
      if (in_ready !== er) begin n_fail++; $display("FAIL rnd_in_ready[%0d]: got %b exp %b", c, in_ready, er); end
      w_en   = wb_valid && (wb_sel != 2'b11) && (wb_rd != 5'd0);
      w_data = (wb_sel == 2'b00) ? alu_result : (wb_sel == 2'b01) ? mem_data : wb_link;
      if (eov && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_sb_empty[%0d]: consumed bundle dest=%0d with no expected entry", c, dest);
        end else begin
          qd = exp_q.pop_front();
          if (dest !== qd) begin n_fail++; $display("FAIL rnd_sb_dest[%0d]: got %0d exp %0d", c, dest, qd); end
        end
      end
      if (in_valid && er) begin
        eb  = model_decode(instruction, pc_plus4, w_en, wb_rd, w_data);
        eov = 1'b1;
        exp_q.push_back(eb.dest);
      end else if (out_ready) begin
        eov = 1'b0;
      end else if (eov) begin
        if (w_en && wb_rd == eb.rs_f) eb.rs_data = w_data;
        if (w_en && wb_rd == eb.rt_f) eb.rt_data = w_data;
      end
      if (w_en) mreg[wb_rd] = w_data;
      step();
      n_checks++;
      if (out_valid !== eov) begin n_fail++; $display("FAIL rnd_out_valid[%0d]: got %b exp %b", c, out_valid, eov); end
      if (eov) begin
        n_checks++;
        if (rs_data !== eb.rs_data || rt_data !== eb.rt_data || imm_ext !== eb.imm ||
            dest !== eb.dest || is_load !== eb.is_load || out_pc_plus4 !== eb.pc) begin
          n_fail++;
          $display("FAIL rnd_bundle[%0d]: got rs=%h rt=%h imm=%h dest=%0d ld=%b pc=%h exp rs=%h rt=%h imm=%h dest=%0d ld=%b pc=%h",
                   c, rs_data, rt_data, imm_ext, dest, is_load, out_pc_plus4,
                   eb.rs_data, eb.rt_data, eb.imm, eb.dest, eb.is_load, eb.pc);
        end
      end
    end
    in_valid = 1'b0; wb_valid = 1'b0; out_ready = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_hazard();
    test_wb_sources();
    test_stall();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
